// File: rtl/riscv_imm_dec_stage.sv
// -----------------------------------------------------------------------------
// riscv_imm_dec_stage
// Decodes the immediate of a RISC-V instruction and buffers the decoded
// immediate plus its one-hot format class in a small circular FIFO.
//
// Parameters:
//   IBUS_DATA_WIDTH : instruction width (32 only)
//   DBUS_DATA_WIDTH : immediate width (32 or 64)
//   DEPTH           : FIFO entries (power of two, >= 2)
//
// Ports:
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   flush           : synchronous discard of every buffered entry
//   in_valid/in_ready/instr           : instruction input handshake
//   out_valid/out_ready/imm/imm_type  : decoded output handshake
//   imm_type one-hot {csr,j,u,b,s,i,r} (bit 6 .. bit 0)
//
// Build option:
//   RISCV_IMM_GEN_ZICSR_EN : when defined, CSR immediate forms (opcode
//   1110011, funct3 101/110/111) decode as csr type with zimm in imm.
// -----------------------------------------------------------------------------
module riscv_imm_dec_stage #(
    parameter int IBUS_DATA_WIDTH = 32,
    parameter int DBUS_DATA_WIDTH = 64,
    parameter int DEPTH           = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IBUS_DATA_WIDTH-1:0] instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DBUS_DATA_WIDTH-1:0] imm,
    output logic [6:0]                 imm_type
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [6:0] KIND_R   = 7'b0000001;
    localparam logic [6:0] KIND_I   = 7'b0000010;
    localparam logic [6:0] KIND_S   = 7'b0000100;
    localparam logic [6:0] KIND_B   = 7'b0001000;
    localparam logic [6:0] KIND_U   = 7'b0010000;
    localparam logic [6:0] KIND_J   = 7'b0100000;
    localparam logic [6:0] KIND_CSR = 7'b1000000;

    typedef struct packed {
        logic [6:0]                 kind;
        logic [DBUS_DATA_WIDTH-1:0] value;
    } dec_t;

    // Every format is first assembled as a 32-bit value and then
    // sign-extended from bit 31, so zero-extended fields (shamt, zimm)
    // simply keep bit 31 clear.
    function automatic dec_t decode(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        logic       is_shift;
        logic [31:0] v;
        logic [6:0] k;
        dec_t       d;
        op       = ins[6:0];
        f3       = ins[14:12];
        is_shift = (f3 == 3'b001) || (f3 == 3'b101);
        v        = 32'h0000_0000;
        k        = 7'b0000000;
        case (op)
            7'b0110011, 7'b0111011: begin
                k = KIND_R;
            end
            7'b0010011: begin
                k = KIND_I;
                if (is_shift) begin
                    // RV64 shifts carry a 6-bit shamt, RV32 a 5-bit one
                    if (DBUS_DATA_WIDTH == 64) begin
                        v = {26'h0, ins[25:20]};
                    end else begin
                        v = {27'h0, ins[24:20]};
                    end
                end else begin
                    v = {{20{ins[31]}}, ins[31:20]};
                end
            end
            7'b0011011: begin
                k = KIND_I;
                if (is_shift) begin
                    v = {27'h0, ins[24:20]};
                end else begin
                    v = {{20{ins[31]}}, ins[31:20]};
                end
            end
            7'b0000011, 7'b1100111: begin
                k = KIND_I;
                v = {{20{ins[31]}}, ins[31:20]};
            end
            7'b0100011: begin
                k = KIND_S;
                v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                k = KIND_B;
                v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                k = KIND_U;
                v = {ins[31:12], 12'h000};
            end
            7'b1101111: begin
                k = KIND_J;
                v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
`ifdef RISCV_IMM_GEN_ZICSR_EN
            7'b1110011: begin
                if (f3[2] && (f3[1:0] != 2'b00)) begin
                    k = KIND_CSR;
                    v = {27'h0, ins[19:15]};
                end else begin
                    k = 7'b0000000;
                end
            end
`endif
            default: begin
                k = 7'b0000000;
            end
        endcase
        d.kind  = k;
        d.value = DBUS_DATA_WIDTH'({{32{v[31]}}, v});
        return d;
    endfunction

    logic [PW-1:0]              wr_ptr_r;
    logic [PW-1:0]              rd_ptr_r;
    logic [CW-1:0]              count_r;
    logic [DBUS_DATA_WIDTH-1:0] mem_imm_r  [DEPTH];
    logic [6:0]                 mem_type_r [DEPTH];
    dec_t                       dec_s;
    logic                       push_s;
    logic                       pop_s;

    // Decode the incoming instruction and form the handshake strobes.
    always_comb begin
        dec_s     = decode(instr[31:0]);
        out_valid = (count_r != {CW{1'b0}});
        in_ready  = (count_r < DEPTH_C) || (out_valid && out_ready);
        pop_s     = out_valid && out_ready;
        push_s    = in_valid && in_ready && !flush;
    end

    // Head of the FIFO; forced to zero whenever the buffer is empty so the
    // outputs read as zero during and right after reset or flush.
    always_comb begin
        if (out_valid) begin
            imm      = mem_imm_r[rd_ptr_r];
            imm_type = mem_type_r[rd_ptr_r];
        end else begin
            imm      = {DBUS_DATA_WIDTH{1'b0}};
            imm_type = 7'b0000000;
        end
    end

    // Pointer and occupancy control; flush discards entries and any push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only observable through the gated head.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_imm_r[wr_ptr_r]  <= dec_s.value;
            mem_type_r[wr_ptr_r] <= dec_s.kind;
        end
    end

endmodule

// File: tb/tb_riscv_imm_dec_stage.sv
// -----------------------------------------------------------------------------
// tb_riscv_imm_dec_stage
// Scoreboard bench for riscv_imm_dec_stage. Two instances (64-bit and 32-bit
// immediates) share one stimulus stream. Expected results come from a
// reference model written from the RISC-V immediate rules, or from literal
// constants for the directed instructions. A negedge monitor checks the
// occupancy-derived handshakes, the FIFO head, and pops on each output beat.
// Honours RISCV_IMM_GEN_ZICSR_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_riscv_imm_dec_stage;

    localparam int DEPTH = 2;

    typedef struct {
        logic [63:0] imm;
        logic [6:0]  kind;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = 32'h0;

    logic        in_ready, out_valid;
    logic [63:0] imm;
    logic [6:0]  imm_type;
    logic        in_ready32, out_valid32;
    logic [31:0] imm32;
    logic [6:0]  imm_type32;

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        q64[$];
    exp_t        q32[$];

    bit          ovr_en = 1'b0;
    logic [63:0] ovr_imm64 = 64'h0;
    logic [63:0] ovr_imm32 = 64'h0;
    logic [6:0]  ovr_kind = 7'h0;

    riscv_imm_dec_stage #(.IBUS_DATA_WIDTH(32), .DBUS_DATA_WIDTH(64), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .imm(imm), .imm_type(imm_type)
    );

    riscv_imm_dec_stage #(.IBUS_DATA_WIDTH(32), .DBUS_DATA_WIDTH(32), .DEPTH(DEPTH)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .out_valid(out_valid32), .out_ready(out_ready), .imm(imm32), .imm_type(imm_type32)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: immediate value as a signed integer, then truncated
    // to the immediate width.
    function automatic exp_t model(input logic [31:0] ins, input int w);
        exp_t       e;
        longint     v;
        logic [2:0] f3;
        bit         sh;
        v      = 0;
        e.kind = 7'h0;
        f3     = ins[14:12];
        sh     = (f3 == 3'd1) || (f3 == 3'd5);
        case (ins[6:0])
            7'h33, 7'h3B: e.kind = 7'b0000001;
            7'h13: begin
                e.kind = 7'b0000010;
                if (sh) v = (w == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
                else    v = longint'($signed(ins[31:20]));
            end
            7'h1B: begin
                e.kind = 7'b0000010;
                if (sh) v = longint'(ins[24:20]);
                else    v = longint'($signed(ins[31:20]));
            end
            7'h03, 7'h67: begin
                e.kind = 7'b0000010;
                v = longint'($signed(ins[31:20]));
            end
            7'h23: begin
                e.kind = 7'b0000100;
                v = longint'($signed({ins[31:25], ins[11:7]}));
            end
            7'h63: begin
                e.kind = 7'b0001000;
                v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            7'h37, 7'h17: begin
                e.kind = 7'b0010000;
                v = longint'($signed({ins[31:12], 12'h000}));
            end
            7'h6F: begin
                e.kind = 7'b0100000;
                v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
`ifdef RISCV_IMM_GEN_ZICSR_EN
            7'h73: begin
                if (f3 >= 3'd5) begin
                    e.kind = 7'b1000000;
                    v = longint'(ins[19:15]);
                end
            end
`endif
            default: ;
        endcase
        e.imm = (w == 32) ? (v & 64'h0000_0000_FFFF_FFFF) : v;
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [6:0]  ops [15];
        logic [31:0] r;
        ops = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h23, 7'h63,
                7'h37, 7'h17, 7'h6F, 7'h73, 7'h13, 7'h0F, 7'h7F};
        r = $urandom;
        if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 14)];
        return r;
    endfunction

    // Monitor: occupancy model is the scoreboard queue length.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("out_valid", {63'h0, out_valid}, {63'h0, q64.size() != 0});
            check("in_ready", {63'h0, in_ready},
                  {63'h0, (q64.size() < DEPTH) || (q64.size() != 0 && out_ready)});
            check("out_valid32", {63'h0, out_valid32}, {63'h0, q32.size() != 0});
            if (out_valid && q64.size() != 0) begin
                check("imm64", imm, q64[0].imm);
                check("imm_type64", {57'h0, imm_type}, {57'h0, q64[0].kind});
            end
            if (out_valid32 && q32.size() != 0) begin
                check("imm32", {32'h0, imm32}, q32[0].imm);
                check("imm_type32", {57'h0, imm_type32}, {57'h0, q32[0].kind});
            end
            if (out_valid && out_ready && q64.size() != 0) void'(q64.pop_front());
            if (out_valid32 && out_ready && q32.size() != 0) void'(q32.pop_front());
            if (flush) begin
                q64.delete();
                q32.delete();
            end else begin
                if (in_valid && in_ready) begin
                    e = model(instr, 64);
                    if (ovr_en) begin e.imm = ovr_imm64; e.kind = ovr_kind; end
                    q64.push_back(e);
                end
                if (in_valid && in_ready32) begin
                    e = model(instr, 32);
                    if (ovr_en) begin e.imm = ovr_imm32; e.kind = ovr_kind; end
                    q32.push_back(e);
                end
            end
        end
    end

    // Offers one beat until it is accepted; called just after a rising edge.
    task automatic send(input logic [31:0] ins, input bit rnd);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        instr = ins;
        for (int c = 0; c < 60 && !acc; c++) begin
            if (rnd) begin
                out_ready = 1'($urandom_range(0, 1));
                flush = ($urandom_range(0, 19) == 0);
            end
            @(negedge clk);
            acc = in_ready && !flush;
            @(posedge clk);
            #1;
        end
        if (rnd) flush = 1'b0;
        in_valid = 1'b0;
        ovr_en = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: instr %08h not accepted within 60 cycles", ins);
        end
    endtask

    task automatic send_dir(input logic [31:0] ins, input logic [63:0] e64,
                            input logic [63:0] e32, input logic [6:0] k);
        ovr_en = 1'b1;
        ovr_imm64 = e64;
        ovr_imm32 = e32;
        ovr_kind = k;
        send(ins, 1'b0);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int c = 0; c < 20 && (q64.size() != 0 || q32.size() != 0); c++) @(negedge clk);
        @(posedge clk);
        #1;
        check("drain_empty", 64'(q64.size() + q32.size()), 64'h0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, {63'h0, out_valid}, 64'h0);
        check({tag, "_imm"}, imm, 64'h0);
        check({tag, "_imm_type"}, {57'h0, imm_type}, 64'h0);
        check({tag, "_out_valid32"}, {63'h0, out_valid32}, 64'h0);
        check({tag, "_imm32"}, {32'h0, imm32}, 64'h0);
    endtask

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #2 check_zero_outputs("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed decodes, free-flowing output
        out_ready = 1'b1;
        send_dir(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF, 7'b0000010);
        send_dir(32'h12345037, 64'h0000_0000_1234_5000, 64'h1234_5000, 7'b0010000);
        send_dir(32'hFFDFF0EF, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFC, 7'b0100000);
        send_dir(32'h43F0D093, 64'h3F, 64'h1F, 7'b0000010);
`ifdef RISCV_IMM_GEN_ZICSR_EN
        send_dir(32'h3402D073, 64'h5, 64'h5, 7'b1000000);
`else
        send_dir(32'h3402D073, 64'h0, 64'h0, 7'b0000000);
`endif
        drain();

        // Fill with output stalled, then simultaneous pop/push when full
        out_ready = 1'b0;
        send(32'h00100093, 1'b0);
        send(32'h00200113, 1'b0);
        in_valid = 1'b1;
        instr = 32'h00300193;
        repeat (3) @(posedge clk);
        #1 check("full_in_ready", {63'h0, in_ready}, 64'h0);
        out_ready = 1'b1;
        send(32'h00300193, 1'b0);
        out_ready = 1'b0;
        drain();

        // Flush with two entries and a concurrent push
        out_ready = 1'b0;
        send(32'hFFF00093, 1'b0);
        send(32'h80000037, 1'b0);
        in_valid = 1'b1;
        instr = 32'h12345037;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check_zero_outputs("flush");

        // Asynchronous reset mid-stream
        send(32'hFFF00093, 1'b0);
        send(32'hFFDFF0EF, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("async_reset");
        q64.delete();
        q32.delete();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("in_ready_after_reset", {63'h0, in_ready}, 64'h1);

        // Randomized traffic with random backpressure and flushes
        for (int n = 0; n < 300; n++) begin
            send(gen_instr(), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_imm_dec_stage.md
RISCV_IMM_DEC_STAGE -- requirements
Module: riscv_imm_dec_stage

Interface
REQ-001 SHALL have parameter IBUS_DATA_WIDTH, default 32: instruction width; only 32 is legal.
REQ-002 SHALL have parameter DBUS_DATA_WIDTH, default 64: immediate width; only 32 or 64 is legal.
REQ-003 SHALL have parameter DEPTH, default 2: output buffer entries; power of two, at least 2.
REQ-004 SHALL have ports: clk  in  1  single clock, rising edge. One clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: flush  in  1  synchronous discard of all buffered entries.
REQ-007 SHALL have ports: in_valid  in  1;  in_ready  out  1;  instr  in  IBUS_DATA_WIDTH.
REQ-008 SHALL have ports: out_valid  out  1;  out_ready  in  1;  imm  out  DBUS_DATA_WIDTH;  imm_type  out  7  one-hot {csr,j,u,b,s,i,r}.

Function
REQ-009 SHALL accept a beat when in_valid and in_ready are both high at a rising edge, and present a beat when out_valid and out_ready are both high.
REQ-010 SHALL drive in_ready = (count < DEPTH) or (out_valid and out_ready), i.e. same-cycle pass-through when full is allowed.
REQ-011 SHALL decode and register each accepted instr, so its imm/imm_type appear at the head no earlier than the cycle after acceptance (latency 1 when empty).
REQ-012 SHALL keep entries in a DEPTH-deep circular FIFO with wrapping read/write pointers and a count of width clog2(DEPTH)+1; out_valid = (count != 0).
REQ-013 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-014 SHALL hold imm and imm_type stable while out_valid is high and out_ready is low.
REQ-015 SHALL classify opcode instr[6:0]: 0110011/0111011 = r; 0010011/0011011/0000011/1100111 = i; 0100011 = s; 1100011 = b; 0110111/0010111 = u; 1101111 = j; anything else = imm_type 0, imm 0.
REQ-016 SHALL produce: i = sext(instr[31:20]); s = sext({instr[31:25],instr[11:7]}); b = sext({instr[31],instr[7],instr[30:25],instr[11:8],0}); u = sext({instr[31:12],12'b0}); j = sext({instr[31],instr[19:12],instr[20],instr[30:21],0}); r = 0.
REQ-017 SHALL, for opcode 0010011 with funct3 001/101, produce zero-extended shamt instr[25:20] when DBUS_DATA_WIDTH = 64 and instr[24:20] when 32; for 0011011 with funct3 001/101, shamt instr[24:20].
REQ-018 SHALL sign-extend from bit 31 of the 32-bit assembled value to DBUS_DATA_WIDTH.
REQ-019 SHALL, on flush, set count and both pointers to 0 at that edge, drop any same-cycle push, and hold out_valid low the following cycle.

Reset
REQ-020 SHALL, while rst_n is low, force count, pointers and out_valid to 0, and imm and imm_type to 0, regardless of clk.
REQ-021 SHALL discard any in-flight beat when reset asserts mid-operation; in_ready is high the first cycle after release.

Configuration
REQ-022 SHALL, with macro RISCV_IMM_GEN_ZICSR_EN defined, decode opcode 1110011 with funct3 101/110/111 as csr type, imm = zero-extended instr[19:15], imm_type bit 6.
REQ-023 SHALL, without RISCV_IMM_GEN_ZICSR_EN, treat opcode 1110011 as unknown (imm 0, imm_type 0); imm_type bit 6 is then constant 0.

Verification
REQ-024 SHALL cover: 64-bit, push 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFFFFFFFFFF, imm_type=0000010.
REQ-025 SHALL cover: 64-bit, push 0x12345037 (lui) -> imm=0x0000000012345000; push 0xFFDFF0EF (jal -4) -> imm=0xFFFFFFFFFFFFFFFC, imm_type=0100000.
REQ-026 SHALL cover: 64-bit, push 0x43F0D093 (srai x1,x1,63) -> imm=0x3F; same instr with DBUS_DATA_WIDTH=32 -> imm=0x1F.
REQ-027 SHALL cover: DEPTH=2, out_ready=0, push 3 beats -> in_ready low after 2; raise out_ready with in_valid held -> pop and push same cycle, count stays 2, order preserved.
REQ-028 SHALL cover: flush with 2 entries and concurrent push -> out_valid=0 next cycle; rst_n low mid-stream -> all outputs 0 immediately, asynchronous to clk.
REQ-029 SHALL cover: macro defined, push 0x3402D073 (csrrwi, zimm 5) -> imm=0x5, imm_type=1000000; undefined -> imm=0, imm_type=0.
